// File: rtl/zx_kbd_pkg.sv
// zx_kbd_pkg: shared definitions for the ZX Spectrum keyboard matrix block.
//   - PS/2 set-2 scancode constants
//   - half-row / column positions of keys with special roles
//   - cs_src / ss_src source indices
//   - decoded-key kind enum and struct, plus small builders for the decoder table
package zx_kbd_pkg;

  // Set-2 scancodes (non-extended unless noted)
  localparam logic [7:0] SC_Z = 8'h1A, SC_X = 8'h22, SC_C = 8'h21, SC_V = 8'h2A;
  localparam logic [7:0] SC_A = 8'h1C, SC_S = 8'h1B, SC_D = 8'h23, SC_F = 8'h2B, SC_G = 8'h34;
  localparam logic [7:0] SC_Q = 8'h15, SC_W = 8'h1D, SC_E = 8'h24, SC_R = 8'h2D, SC_T = 8'h2C;
  localparam logic [7:0] SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26, SC_4 = 8'h25, SC_5 = 8'h2E;
  localparam logic [7:0] SC_0 = 8'h45, SC_9 = 8'h46, SC_8 = 8'h3E, SC_7 = 8'h3D, SC_6 = 8'h36;
  localparam logic [7:0] SC_P = 8'h4D, SC_O = 8'h44, SC_I = 8'h43, SC_U = 8'h3C, SC_Y = 8'h35;
  localparam logic [7:0] SC_ENTER = 8'h5A, SC_L = 8'h4B, SC_K = 8'h42, SC_J = 8'h3B, SC_H = 8'h33;
  localparam logic [7:0] SC_SPACE = 8'h29, SC_M = 8'h3A, SC_N = 8'h31, SC_B = 8'h32;
  localparam logic [7:0] SC_LSHIFT = 8'h12, SC_RSHIFT = 8'h59, SC_CTRL = 8'h14;
  localparam logic [7:0] SC_BKSP = 8'h66, SC_ESC = 8'h76, SC_BAT = 8'hAA;
  // Extended (E0-prefixed) cursor keys
  localparam logic [7:0] SC_E_LEFT = 8'h6B, SC_E_DOWN = 8'h72, SC_E_UP = 8'h75, SC_E_RIGHT = 8'h74;
  // Function keys F1..F12
  localparam logic [7:0] SC_F1 = 8'h05, SC_F2 = 8'h06, SC_F3  = 8'h04, SC_F4  = 8'h0C;
  localparam logic [7:0] SC_F5 = 8'h03, SC_F6 = 8'h0B, SC_F7  = 8'h83, SC_F8  = 8'h0A;
  localparam logic [7:0] SC_F9 = 8'h01, SC_F10 = 8'h09, SC_F11 = 8'h78, SC_F12 = 8'h07;

  // Flat matrix positions: half-row * 5 + column
  localparam int unsigned POS_CS    = 0;   // r0b0 CAPS SHIFT
  localparam int unsigned POS_SS    = 36;  // r7b1 SYMBOL SHIFT
  localparam int unsigned POS_0     = 20;  // r4b0
  localparam int unsigned POS_5     = 19;  // r3b4
  localparam int unsigned POS_6     = 24;  // r4b4
  localparam int unsigned POS_7     = 23;  // r4b3
  localparam int unsigned POS_8     = 22;  // r4b2
  localparam int unsigned POS_SPACE = 35;  // r7b0

  // cs_src bit indices
  localparam logic [3:0] CS_LSHIFT = 4'd0, CS_RSHIFT = 4'd1, CS_BKSP = 4'd2, CS_LEFT = 4'd3;
  localparam logic [3:0] CS_DOWN   = 4'd4, CS_UP     = 4'd5, CS_RIGHT = 4'd6, CS_ESC = 4'd7;
  // ss_src bit indices
  localparam logic [3:0] SS_LCTRL = 4'd0, SS_RCTRL = 4'd1;

  typedef enum logic [2:0] {
    KIND_BASE,
    KIND_CS_SRC,
    KIND_SS_SRC,
    KIND_COMPOUND,
    KIND_CLEAR,
    KIND_FKEY
  } key_kind_e;

  typedef struct packed {
    logic       valid;
    key_kind_e  kind;
    logic [2:0] row;
    logic [2:0] col;
    logic [3:0] src;
  } key_dec_t;

  function automatic key_dec_t dec_base(input logic [2:0] r, input logic [2:0] c);
    return '{valid: 1'b1, kind: KIND_BASE, row: r, col: c, src: 4'd0};
  endfunction

  function automatic key_dec_t dec_src(input key_kind_e k, input logic [3:0] s);
    return '{valid: 1'b1, kind: k, row: 3'd0, col: 3'd0, src: s};
  endfunction

  function automatic logic [5:0] key_idx(input logic [2:0] r, input logic [2:0] c);
    return ({3'b000, r} * 6'd5) + {3'b000, c};
  endfunction

endpackage

// File: rtl/zx_keymap.sv
// zx_keymap: registered scancode decoder (stage 2).
//   i_clock, i_reset : clock, sync active-high reset (clears the valid only)
//   i_vld_p0         : stage-1 event valid
//   i_ext_p0/i_code_p0 : stage-1 extended flag and set-2 scancode
//   o_key_p1         : decoded key {valid, kind, row, col, src}
// Optional macro ZX_KBD_FKEYS_EN adds F1..F12 decoding (KIND_FKEY).
module zx_keymap
  import zx_kbd_pkg::*;
#(
  parameter int CLEAR_ON_BAT = 1,
  parameter int SYM_ON_RCTRL = 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_vld_p0,
  input  logic       i_ext_p0,
  input  logic [7:0] i_code_p0,
  output key_dec_t   o_key_p1
);

  key_dec_t w_dec;
  key_dec_t r_dec_p1;
  logic     r_vld_p1;

  always_comb begin
    w_dec = '0;
    case ({i_ext_p0, i_code_p0})
      {1'b0, SC_Z}:     w_dec = dec_base(3'd0, 3'd1);
      {1'b0, SC_X}:     w_dec = dec_base(3'd0, 3'd2);
      {1'b0, SC_C}:     w_dec = dec_base(3'd0, 3'd3);
      {1'b0, SC_V}:     w_dec = dec_base(3'd0, 3'd4);
      {1'b0, SC_A}:     w_dec = dec_base(3'd1, 3'd0);
      {1'b0, SC_S}:     w_dec = dec_base(3'd1, 3'd1);
      {1'b0, SC_D}:     w_dec = dec_base(3'd1, 3'd2);
      {1'b0, SC_F}:     w_dec = dec_base(3'd1, 3'd3);
      {1'b0, SC_G}:     w_dec = dec_base(3'd1, 3'd4);
      {1'b0, SC_Q}:     w_dec = dec_base(3'd2, 3'd0);
      {1'b0, SC_W}:     w_dec = dec_base(3'd2, 3'd1);
      {1'b0, SC_E}:     w_dec = dec_base(3'd2, 3'd2);
      {1'b0, SC_R}:     w_dec = dec_base(3'd2, 3'd3);
      {1'b0, SC_T}:     w_dec = dec_base(3'd2, 3'd4);
      {1'b0, SC_1}:     w_dec = dec_base(3'd3, 3'd0);
      {1'b0, SC_2}:     w_dec = dec_base(3'd3, 3'd1);
      {1'b0, SC_3}:     w_dec = dec_base(3'd3, 3'd2);
      {1'b0, SC_4}:     w_dec = dec_base(3'd3, 3'd3);
      {1'b0, SC_5}:     w_dec = dec_base(3'd3, 3'd4);
      {1'b0, SC_0}:     w_dec = dec_base(3'd4, 3'd0);
      {1'b0, SC_9}:     w_dec = dec_base(3'd4, 3'd1);
      {1'b0, SC_8}:     w_dec = dec_base(3'd4, 3'd2);
      {1'b0, SC_7}:     w_dec = dec_base(3'd4, 3'd3);
      {1'b0, SC_6}:     w_dec = dec_base(3'd4, 3'd4);
      {1'b0, SC_P}:     w_dec = dec_base(3'd5, 3'd0);
      {1'b0, SC_O}:     w_dec = dec_base(3'd5, 3'd1);
      {1'b0, SC_I}:     w_dec = dec_base(3'd5, 3'd2);
      {1'b0, SC_U}:     w_dec = dec_base(3'd5, 3'd3);
      {1'b0, SC_Y}:     w_dec = dec_base(3'd5, 3'd4);
      {1'b0, SC_ENTER}: w_dec = dec_base(3'd6, 3'd0);
      {1'b0, SC_L}:     w_dec = dec_base(3'd6, 3'd1);
      {1'b0, SC_K}:     w_dec = dec_base(3'd6, 3'd2);
      {1'b0, SC_J}:     w_dec = dec_base(3'd6, 3'd3);
      {1'b0, SC_H}:     w_dec = dec_base(3'd6, 3'd4);
      {1'b0, SC_SPACE}: w_dec = dec_base(3'd7, 3'd0);
      {1'b0, SC_M}:     w_dec = dec_base(3'd7, 3'd2);
      {1'b0, SC_N}:     w_dec = dec_base(3'd7, 3'd3);
      {1'b0, SC_B}:     w_dec = dec_base(3'd7, 3'd4);
      {1'b0, SC_LSHIFT}:  w_dec = dec_src(KIND_CS_SRC, CS_LSHIFT);
      {1'b0, SC_RSHIFT}:  w_dec = dec_src(KIND_CS_SRC, CS_RSHIFT);
      {1'b0, SC_BKSP}:    w_dec = dec_src(KIND_COMPOUND, CS_BKSP);
      {1'b1, SC_E_LEFT}:  w_dec = dec_src(KIND_COMPOUND, CS_LEFT);
      {1'b1, SC_E_DOWN}:  w_dec = dec_src(KIND_COMPOUND, CS_DOWN);
      {1'b1, SC_E_UP}:    w_dec = dec_src(KIND_COMPOUND, CS_UP);
      {1'b1, SC_E_RIGHT}: w_dec = dec_src(KIND_COMPOUND, CS_RIGHT);
      {1'b0, SC_ESC}:     w_dec = dec_src(KIND_COMPOUND, CS_ESC);
      {1'b0, SC_CTRL}:    w_dec = dec_src(KIND_SS_SRC, SS_LCTRL);
      {1'b1, SC_CTRL}: begin
        if (SYM_ON_RCTRL != 0) w_dec = dec_src(KIND_SS_SRC, SS_RCTRL);
      end
      {1'b0, SC_BAT}: begin
        if (CLEAR_ON_BAT != 0) w_dec = dec_src(KIND_CLEAR, 4'd0);
      end
`ifdef ZX_KBD_FKEYS_EN
      {1'b0, SC_F1}:  w_dec = dec_src(KIND_FKEY, 4'd0);
      {1'b0, SC_F2}:  w_dec = dec_src(KIND_FKEY, 4'd1);
      {1'b0, SC_F3}:  w_dec = dec_src(KIND_FKEY, 4'd2);
      {1'b0, SC_F4}:  w_dec = dec_src(KIND_FKEY, 4'd3);
      {1'b0, SC_F5}:  w_dec = dec_src(KIND_FKEY, 4'd4);
      {1'b0, SC_F6}:  w_dec = dec_src(KIND_FKEY, 4'd5);
      {1'b0, SC_F7}:  w_dec = dec_src(KIND_FKEY, 4'd6);
      {1'b0, SC_F8}:  w_dec = dec_src(KIND_FKEY, 4'd7);
      {1'b0, SC_F9}:  w_dec = dec_src(KIND_FKEY, 4'd8);
      {1'b0, SC_F10}: w_dec = dec_src(KIND_FKEY, 4'd9);
      {1'b0, SC_F11}: w_dec = dec_src(KIND_FKEY, 4'd10);
      {1'b0, SC_F12}: w_dec = dec_src(KIND_FKEY, 4'd11);
`endif
      default: w_dec = '0;
    endcase
  end

  // ---- stage 2 boundary: decoded key register ----
  always_ff @(posedge i_clock) begin
    if (i_reset) r_vld_p1 <= 1'b0;
    else         r_vld_p1 <= i_vld_p0 & w_dec.valid;
  end

  always_ff @(posedge i_clock) begin
    r_dec_p1 <= w_dec;
  end

  always_comb begin
    o_key_p1       = r_dec_p1;
    o_key_p1.valid = r_vld_p1;
  end

endmodule

// File: rtl/zx_keyboard_matrix.sv
// zx_keyboard_matrix: PS/2 set-2 key events -> ZX Spectrum 8x5 half-row matrix.
//   clock  : system clock
//   reset  : synchronous active-high, clears all key state and pipeline valids
//   kstb   : one-cycle event strobe; make (0 = press, 1 = release); ext (E0 prefix)
//   code   : set-2 scancode
//   row    : A15..A8, a 0 in bit n selects half-row n
//   cols   : active-low columns D4..D0 (combinational from state and row)
//   fkey   : F1..F12 held state (only with ZX_KBD_FKEYS_EN defined)
// Latency: kstb in cycle N is first visible on cols/fkey in cycle N+3.
module zx_keyboard_matrix
  import zx_kbd_pkg::*;
#(
  parameter int CLEAR_ON_BAT = 1,
  parameter int SYM_ON_RCTRL = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        kstb,
  input  logic        make,
  input  logic        ext,
  input  logic [7:0]  code,
  input  logic [7:0]  row,
  output logic [4:0]  cols
`ifdef ZX_KBD_FKEYS_EN
  ,
  output logic [11:0] fkey
`endif
);

  logic       r_vld_p0;
  logic       r_make_p0;
  logic       r_ext_p0;
  logic [7:0] r_code_p0;
  logic       r_make_p1;
  key_dec_t   w_key_p1;

  logic [39:0] r_base;
  logic [7:0]  r_cs_src;
  logic [1:0]  r_ss_src;
  logic [39:0] w_mask;
  logic [39:0] w_matrix;
  logic [4:0]  w_cols_hit;

  // ---- stage 1 boundary: input event register ----
  always_ff @(posedge clock) begin
    if (reset) r_vld_p0 <= 1'b0;  // drops a kstb coincident with reset
    else       r_vld_p0 <= kstb;
  end

  always_ff @(posedge clock) begin
    r_make_p0 <= make;
    r_ext_p0  <= ext;
    r_code_p0 <= code;
  end

  // ---- stage 2 boundary: decode ----
  zx_keymap #(
    .CLEAR_ON_BAT (CLEAR_ON_BAT),
    .SYM_ON_RCTRL (SYM_ON_RCTRL)
  ) u_keymap (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_vld_p0  (r_vld_p0),
    .i_ext_p0  (r_ext_p0),
    .i_code_p0 (r_code_p0),
    .o_key_p1  (w_key_p1)
  );

  always_ff @(posedge clock) begin
    r_make_p1 <= r_make_p0;
  end

  assign w_mask = 40'd1 << key_idx(w_key_p1.row, w_key_p1.col);

`ifdef ZX_KBD_FKEYS_EN
  logic [11:0] r_fkey;
  assign fkey = r_fkey;
`else
  logic w_unused_src;
  assign w_unused_src = w_key_p1.src[3];
`endif

  // ---- stage 3 boundary: key state update ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_base   <= '0;
      r_cs_src <= '0;
      r_ss_src <= '0;
`ifdef ZX_KBD_FKEYS_EN
      r_fkey   <= '0;
`endif
    end else if (w_key_p1.valid) begin
      case (w_key_p1.kind)
        KIND_BASE:
          r_base <= r_make_p1 ? (r_base & ~w_mask) : (r_base | w_mask);
        KIND_CS_SRC, KIND_COMPOUND:
          r_cs_src[w_key_p1.src[2:0]] <= ~r_make_p1;
        KIND_SS_SRC:
          r_ss_src[w_key_p1.src[0]] <= ~r_make_p1;
        KIND_CLEAR: begin
          r_base   <= '0;
          r_cs_src <= '0;
          r_ss_src <= '0;
`ifdef ZX_KBD_FKEYS_EN
          r_fkey   <= '0;
`endif
        end
`ifdef ZX_KBD_FKEYS_EN
        KIND_FKEY:
          r_fkey[w_key_p1.src] <= ~r_make_p1;
`endif
        default: ;
      endcase
    end
  end

  // Effective matrix: shift keys and compound sources OR onto their positions so
  // each source is released independently of the others.
  always_comb begin
    w_matrix            = r_base;
    w_matrix[POS_CS]    = r_base[POS_CS] | (|r_cs_src);
    w_matrix[POS_SS]    = r_base[POS_SS] | (|r_ss_src);
    w_matrix[POS_0]     = r_base[POS_0]     | r_cs_src[CS_BKSP[2:0]];
    w_matrix[POS_5]     = r_base[POS_5]     | r_cs_src[CS_LEFT[2:0]];
    w_matrix[POS_6]     = r_base[POS_6]     | r_cs_src[CS_DOWN[2:0]];
    w_matrix[POS_7]     = r_base[POS_7]     | r_cs_src[CS_UP[2:0]];
    w_matrix[POS_8]     = r_base[POS_8]     | r_cs_src[CS_RIGHT[2:0]];
    w_matrix[POS_SPACE] = r_base[POS_SPACE] | r_cs_src[CS_ESC[2:0]];
  end

  always_comb begin
    w_cols_hit = '0;
    for (int n = 0; n < 8; n++) begin
      if (!row[n]) w_cols_hit = w_cols_hit | w_matrix[n*5 +: 5];
    end
  end

  assign cols = ~w_cols_hit;

endmodule
